// File: rtl/muldiv_unit_if.sv
// Handshake and data bundle between the control unit (master) and the
// iterative multiply/divide unit that owns HI/LO (slave).
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, op, A, B, mthi, mtlo,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, op, A, B, mthi, mtlo,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO ownership: one shift-add or
// restoring shift-subtract step per clock, one sign-fix cycle, one commit cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   w_load;
    logic                   w_step;
    logic                   w_fix;
    logic                   w_signed;

    logic [CW-1:0]          r_count;
    logic                   r_is_div;
    logic                   r_neg_res;
    logic                   r_neg_rem;
    logic                   r_divz;
    logic [WIDTH-1:0]       r_opb;
    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]       r_res_hi;
    logic [WIDTH-1:0]       r_res_lo;
    logic                   r_commit;
    logic                   r_busy;
    logic                   r_done;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;

    logic [2*WIDTH-1:0]     w_acc_step;
    logic [WIDTH:0]         w_rem_sh;
    logic [WIDTH-1:0]       w_diff;
    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH-1:0]     w_prod;
    logic [WIDTH-1:0]       w_fix_hi;
    logic [WIDTH-1:0]       w_fix_lo;

    // Unsigned magnitude: 0x80000000 maps to itself, which is the correct unsigned value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            magnitude = -v;
        end else begin
            magnitude = v;
        end
    endfunction

    assign w_signed = ~bus.op[0];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_next_state = S_CALC;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_count == CNT_LAST) begin
                    w_next_state = S_FIX;
                end else begin
                    w_next_state = S_CALC;
                end
            end
            S_FIX:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM control outputs; start is refused until the previous result has been committed
    always_comb begin
        w_load = 1'b0;
        w_step = 1'b0;
        w_fix  = 1'b0;
        case (r_state)
            S_IDLE:  w_load = bus.start & ~r_busy;
            S_CALC:  w_step = 1'b1;
            S_FIX:   w_fix  = 1'b1;
            default: w_load = 1'b0;
        endcase
    end

    // One iteration: acc = {remainder/partial-product high, quotient/multiplier low}
    always_comb begin
        w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_diff     = w_rem_sh[WIDTH-1:0] - r_opb;
        w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
        w_acc_step = r_acc;
        if (r_is_div) begin
            if (w_rem_sh >= {1'b0, r_opb}) begin
                w_acc_step = {w_diff, r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_step = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_step = {w_sum, r_acc[WIDTH-1:1]};
        end
    end

    // Sign correction; a zero divisor leaves the quotient raw, and the remainder fix restores A
    always_comb begin
        w_prod   = r_neg_res ? -r_acc : r_acc;
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            w_fix_lo = (r_neg_res && !r_divz) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            w_fix_hi = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        end else begin
            w_fix_lo = w_prod[WIDTH-1:0];
        end
    end

    // Operand latch, iteration datapath and corrected-result staging
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count   <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_divz    <= 1'b0;
            r_opb     <= '0;
            r_acc     <= '0;
            r_res_hi  <= '0;
            r_res_lo  <= '0;
            r_commit  <= 1'b0;
        end else begin
            r_commit <= w_fix;
            if (w_load) begin
                r_count   <= '0;
                r_is_div  <= bus.op[1];
                r_neg_res <= w_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                r_neg_rem <= w_signed & bus.op[1] & bus.A[WIDTH-1];
                r_divz    <= (bus.B == {WIDTH{1'b0}});
                r_opb     <= magnitude(bus.B, w_signed);
                r_acc     <= {{WIDTH{1'b0}}, magnitude(bus.A, w_signed)};
            end else if (w_step) begin
                r_count <= r_count + CNT_ONE;
                r_acc   <= w_acc_step;
            end else if (w_fix) begin
                r_res_hi <= w_fix_hi;
                r_res_lo <= w_fix_lo;
            end else begin
                r_count <= r_count;
            end
        end
    end

    // Architectural HI/LO plus registered busy/done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_done <= r_commit;
            if (r_commit) begin
                r_busy <= 1'b0;
                r_hi   <= r_res_hi;
                r_lo   <= r_res_lo;
            end else if (!r_busy) begin
                r_busy <= w_load;
                if (bus.mthi) begin
                    r_hi <= bus.A;
                end else begin
                    r_hi <= r_hi;
                end
                if (bus.mtlo) begin
                    r_lo <= bus.A;
                end else begin
                    r_lo <= r_lo;
                end
            end else begin
                r_busy <= r_busy;
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, latency, divide-by-zero,
// overflow corners, abort on reset and MTHI/MTLO interaction.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Waits after the start edge until done; lat is the edge index of done, -1 on timeout.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = 0;
        for (int i = 1; i <= 60 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) lat = i;
            if (bus.busy === 1'b1) busy_cnt++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cnt);
        int l;
        int bc;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.A = 32'hDEAD_BEEF; bus.B = 32'h0; bus.op = ~op;
        bc = (bus.busy === 1'b1) ? 1 : 0;
        wait_done(l, busy_cnt);
        busy_cnt += bc;
        lat = l;
    endtask

    task automatic op_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        int bc;
        run_op(op, a, b, lat, bc);
        check_val({tag, "_lat"}, 64'(lat), 64'd34);
        check_val({tag, "_hi"}, {32'h0, bus.HI}, {32'h0, exp_hi});
        check_val({tag, "_lo"}, {32'h0, bus.LO}, {32'h0, exp_lo});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bc;
        int seen;
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.A = '0; bus.B = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        #12;
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_done", 64'(bus.done), 64'd0);
        check_val("rst_hi", {32'h0, bus.HI}, 64'h0);
        check_val("rst_lo", {32'h0, bus.LO}, 64'h0);
        @(negedge clk); reset = 1'b1;

        // MULTU max x max with latency, busy length and single-cycle done
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
        check_val("multu_lat", 64'(lat), 64'd34);
        check_val("multu_busy", 64'(bc), 64'd34);
        check_val("multu_hi", {32'h0, bus.HI}, 64'hFFFF_FFFE);
        check_val("multu_lo", {32'h0, bus.LO}, 64'h0000_0001);
        @(posedge clk); #1;
        check_val("multu_done_1cyc", 64'(bus.done), 64'd0);

        // Asynchronous reset mid-operation aborts with no later write
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.A = 32'd5; bus.B = 32'd7;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b0; #1;
        check_val("abort_busy", 64'(bus.busy), 64'd0);
        check_val("abort_done", 64'(bus.done), 64'd0);
        check_val("abort_hi", {32'h0, bus.HI}, 64'h0);
        check_val("abort_lo", {32'h0, bus.LO}, 64'h0);
        @(negedge clk); reset = 1'b1;
        seen = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen++;
        end
        check_val("abort_no_done", 64'(seen), 64'd0);
        check_val("abort_lo_hold", {32'h0, bus.LO}, 64'h0);

        op_check("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        op_check("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        op_check("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        op_check("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        op_check("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        op_check("divu_z", 2'b11, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
        op_check("div_z_neg", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        op_check("mult_pos", 2'b00, 32'd1234, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_F65C);

        // MTHI / MTLO while idle
        @(negedge clk); bus.mthi = 1'b1; bus.A = 32'h0000_1234;
        @(posedge clk); #1; bus.mthi = 1'b0;
        check_val("mthi_idle", {32'h0, bus.HI}, 64'h1234);
        @(negedge clk); bus.mtlo = 1'b1; bus.A = 32'h0000_AAAA;
        @(posedge clk); #1; bus.mtlo = 1'b0;
        check_val("mtlo_idle", {32'h0, bus.LO}, 64'hAAAA);
        check_val("mtlo_hi_hold", {32'h0, bus.HI}, 64'h1234);

        // DIVU launched; start and mtlo while busy must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.A = 32'd100; bus.B = 32'd7;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.mtlo = 1'b1; bus.op = 2'b01; bus.A = 32'h5555; bus.B = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mtlo = 1'b0;
        check_val("busy_mtlo_lo", {32'h0, bus.LO}, 64'hAAAA);
        check_val("busy_still", 64'(bus.busy), 64'd1);
        seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen++;
        end
        check_val("restart_one_done", 64'(seen), 64'd1);
        check_val("restart_hi", {32'h0, bus.HI}, 64'd2);
        check_val("restart_lo", {32'h0, bus.LO}, 64'd14);

        // MTLO coinciding with start: move first, result overwrites at done
        @(negedge clk);
        bus.start = 1'b1; bus.mtlo = 1'b1; bus.op = 2'b01; bus.A = 32'd6; bus.B = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mtlo = 1'b0;
        check_val("mtlo_start_lo", {32'h0, bus.LO}, 64'd6);
        wait_done(lat, bc);
        check_val("mtlo_start_lat", 64'(lat), 64'd34);
        check_val("mtlo_start_res_lo", {32'h0, bus.LO}, 64'd42);
        check_val("mtlo_start_res_hi", {32'h0, bus.HI}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit that owns the HI/LO register pair.
- Executes MULT, MULTU, DIV and DIVU, the operations outside the single-cycle ALU function space.
- Sits beside the ALU in the execute stage. The control unit issues an op with a start pulse and stalls the pipeline while busy=1.
- Also serves MTHI/MTLO writes. HI/LO are read combinationally by the MFHI/MFLO datapath.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  launch request, sampled on the rising edge.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  input  WIDTH  multiplicand/dividend (rs); also the write data for MTHI/MTLO.
- B  input  WIDTH  multiplier/divisor (rt).
- mthi  input  1  write A into HI.
- mtlo  input  1  write A into LO.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: HI/LO were just updated by a mult/div.
- HI  output  WIDTH  HI register (product high word / remainder).
- LO  output  WIDTH  LO register (product low word / quotient).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, HI=0, LO=0, count=0. Asserting reset mid-operation aborts it; no partial result is written.
- States: IDLE, CALC, FIX.
  - IDLE: if start=1, latch op, magnitudes of A/B (signed ops take the absolute value; unsigned pass through), result sign, remainder sign (the sign of A for DIV) and divide-by-zero flag (B==0). Clear the accumulator and count, then go to CALC. busy=1 from the next cycle.
  - CALC: one iteration per clock.
    - Multiply: shift-add, 2*WIDTH-bit accumulator.
    - Divide: restoring shift-subtract, WIDTH-bit remainder.
    - count increments each cycle; after the WIDTH-th iteration go to FIX.
  - FIX: one cycle of sign correction.
    - MULT: negate the 64-bit product if the operand signs differ.
    - DIV: negate the quotient if the operand signs differ; negate the remainder if A was negative.
    - Write {HI,LO}=product, or HI=remainder and LO=quotient. Go to IDLE.
- Outputs after FIX: busy=0 and done=1 for exactly one cycle (registered).
- Latency: start sampled at edge T0; HI/LO valid and done=1 after edge T(WIDTH+2), i.e. edge T34 for WIDTH=32. busy=1 for WIDTH+2 cycles.
- start while busy=1 is ignored; op/A/B changes during CALC have no effect.
- Divide by zero:
  - DIVU: LO=all ones, HI=A.
  - DIV: the same raw values with no sign correction, so LO=0xFFFFFFFF and HI=A.
  - No exception is raised.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (two's-complement wrap). No exception.
- MULT of 0x80000000 by 0x80000000: {HI,LO}=0x40000000_00000000. Magnitudes are held in WIDTH+1 bits or handled as unsigned WIDTH bits.
- mthi/mtlo:
  - Honoured only when busy=0; written at the clock edge and visible the next cycle.
  - Ignored while busy=1; the control unit must stall them.
  - If mthi or mtlo coincides with start in IDLE, the move executes and the operation result later overwrites both registers.
- done is never asserted for mthi/mtlo.
- HI/LO hold their values in all other cycles.

Test Plan:
- Reset mid-op: start MULTU 5×7, assert reset=0 at cycle 10 → busy=0, done=0, HI=LO=0 immediately (asynchronous); no write after reset is released.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; done pulses exactly 34 cycles after the start edge; busy=1 for 34 cycles.
- MULT 0xFFFFFFFD(-3)×7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000×0x80000000 → HI=0x40000000, LO=0.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 9/0 → LO=0xFFFFFFFF, HI=9, no hang. Start pulsed again while busy → ignored; only one done pulse.
- mthi A=0x1234 while idle → HI=0x1234 next cycle. mtlo during busy → LO unchanged. mtlo coinciding with start → LO takes A, then the operation result at done.
